// File: rtl/mem_access_seq_pkg.sv
// Shared MEM-stage access definitions: sequencer states, word geometry, byte-lane select.
// Imported by the MEM-stage sequencer, its lane mux, and the pipeline hazard logic.
package mem_access_seq_pkg;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    // One-hot lane mask for byte index idx within a word.
    function automatic logic [WORD_BYTES-1:0] lane_sel(input logic [CNT_W-1:0] idx);
        lane_sel      = '0;
        lane_sel[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mem_byte_lane_mux.sv
// Byte-lane steering: picks the store byte for the current lane and inserts the read byte.
// Latency: combinational.
// Backpressure: none, pure datapath.
module mem_byte_lane_mux
    import mem_access_seq_pkg::*;
#(
    parameter int BYTE_W = 8
) (
    input  logic [CNT_W-1:0]             lane,
    input  logic [WORD_BYTES*BYTE_W-1:0] wdata,
    input  logic [WORD_BYTES*BYTE_W-1:0] acc,
    input  logic [BYTE_W-1:0]            rd_byte,
    output logic [BYTE_W-1:0]            wr_byte,
    output logic [WORD_BYTES*BYTE_W-1:0] acc_next
);

    logic [WORD_BYTES-1:0] sel;

    always_comb begin
        sel      = lane_sel(lane);
        wr_byte  = '0;
        acc_next = acc;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (sel[i]) begin
                wr_byte                       = wdata[i*BYTE_W +: BYTE_W];
                acc_next[i*BYTE_W +: BYTE_W]  = rd_byte;
            end
        end
    end

endmodule

// File: rtl/mem_access_seq.sv
// MEM-stage sequencer: splits a byte/word load or store into byte cycles on an 8-bit memory.
// Latency: word = 4 byte cycles + 1 response cycle, byte = 1 + 1; accepts again in the following IDLE.
// Backpressure: req_ready only in IDLE, busy stalls the pipeline; response is never held off.
module mem_access_seq
    import mem_access_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BYTE_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic                         req_word,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [WORD_BYTES*BYTE_W-1:0] req_wdata,
    output logic                         resp_valid,
    output logic [WORD_BYTES*BYTE_W-1:0] resp_rdata,
    output logic                         busy,
    output logic [ADDR_W-1:0]            mem_address,
    output logic                         mem_wren,
    output logic [BYTE_W-1:0]            mem_w_data,
    input  logic [BYTE_W-1:0]            mem_r_data
);

    localparam int DATA_W = WORD_BYTES * BYTE_W;

    seq_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic              word_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] rdata_q;
    logic [BYTE_W-1:0] wr_byte;
    logic              last_byte;
    logic              accept;

    mem_byte_lane_mux #(.BYTE_W(BYTE_W)) u_lane_mux (
        .lane     (cnt),
        .wdata    (wdata_q),
        .acc      (acc),
        .rd_byte  (mem_r_data),
        .wr_byte  (wr_byte),
        .acc_next (acc_next)
    );

    // cnt parks on the last lane after an access so address/data hold their final value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            word_q  <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            acc     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= req_we;
                word_q  <= req_word;
                base_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= '0;
                acc     <= '0;
            end
            if (state == XFER) begin
                if (!we_q) begin
                    acc <= acc_next;
                end
                if (last_byte) begin
                    rdata_q <= we_q ? '0 : acc_next;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = (state == IDLE);
        busy       = (state != IDLE);
        resp_valid = (state == RESP);
        mem_wren   = !((state == XFER) && we_q);
        last_byte  = !word_q || (cnt == CNT_W'(WORD_BYTES - 1));
        accept     = req_valid && (state == IDLE);
        case (state)
            IDLE:    if (accept) state_nxt = XFER;
            XFER:    if (last_byte) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_address = base_q + ADDR_W'(cnt);
    assign mem_w_data  = wr_byte;
    assign resp_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: byte-wide memory beside the DUT, request-level reference model.
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_word;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;
    logic [7:0]  mem_address;
    logic        mem_wren;
    logic [7:0]  mem_w_data;
    logic [7:0]  mem_r_data;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    mem_access_seq dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_word    (req_word),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .busy        (busy),
        .mem_address (mem_address),
        .mem_wren    (mem_wren),
        .mem_w_data  (mem_w_data),
        .mem_r_data  (mem_r_data)
    );

    assign mem_r_data = mem[mem_address];

    always @(posedge clk) begin
        if (!mem_wren) mem[mem_address] <= mem_w_data;
    end

    // One transaction: wait for ready, accept, then check every byte cycle and the response
    // against the request-level model. hold keeps req_valid high with the next request's fields.
    task automatic do_req(input logic we, input logic word, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic hold,
                          input logic nwe, input logic nword, input logic [7:0] naddr,
                          input logic [31:0] nwdata, output int waited);
        int          nb;
        logic [31:0] exp_rd;
        logic [7:0]  a;
        nb        = word ? 4 : 1;
        req_we    = we;
        req_word  = word;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (!req_ready) begin
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, waited);
            errs++;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (hold) begin
            req_we = nwe; req_word = nword; req_addr = naddr; req_wdata = nwdata;
        end else begin
            req_valid = 1'b0;
            req_we = 1'($urandom); req_word = 1'($urandom);
            req_addr = 8'($urandom); req_wdata = $urandom;
        end
        exp_rd = '0;
        for (int i = 0; i < nb; i++) begin
            a = addr + 8'(i);
            @(negedge clk);
            vectors++;
            if ({busy, resp_valid, req_ready} !== 3'b100) begin
                $display("FAIL xfer_status byte %0d: busy/resp_valid/req_ready=%b, required 100", i, {busy, resp_valid, req_ready});
                errs++;
            end
            vectors++;
            if (mem_address !== a || mem_wren !== !we) begin
                $display("FAIL xfer_addr byte %0d: addr=%h wren=%b, required addr=%h wren=%b", i, mem_address, mem_wren, a, !we);
                errs++;
            end
            if (we) begin
                vectors++;
                if (mem_w_data !== wdata[8*i +: 8]) begin
                    $display("FAIL xfer_wdata byte %0d: %h, required %h", i, mem_w_data, wdata[8*i +: 8]);
                    errs++;
                end
                ref_mem[a] = wdata[8*i +: 8];
            end else begin
                exp_rd[8*i +: 8] = ref_mem[a];
            end
        end
        @(negedge clk);
        vectors++;
        if (resp_valid !== 1'b1 || busy !== 1'b1 || resp_rdata !== exp_rd) begin
            $display("FAIL resp: resp_valid=%b busy=%b rdata=%h, required 1 1 %h", resp_valid, busy, resp_rdata, exp_rd);
            errs++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_word = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        #12;
        vectors++;
        if ({req_ready, busy, resp_valid, mem_wren} !== 4'b1001) begin
            $display("FAIL reset_ctrl: ready/busy/resp_valid/wren=%b, required 1001", {req_ready, busy, resp_valid, mem_wren});
            errs++;
        end
        vectors++;
        if (resp_rdata !== 32'h0 || mem_address !== 8'h0 || mem_w_data !== 8'h0) begin
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, required 0 0 0", resp_rdata, mem_address, mem_w_data);
            errs++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_and_byte();
        int w;
        do_req(1'b1, 1'b1, 8'h85, 32'h0000_0315, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, w);
        vectors++;
        if ({mem[8'h88], mem[8'h87], mem[8'h86], mem[8'h85]} !== 32'h0000_0315) begin
            $display("FAIL word_store_mem: %h, required 00000315", {mem[8'h88], mem[8'h87], mem[8'h86], mem[8'h85]});
            errs++;
        end
        do_req(1'b0, 1'b1, 8'h85, $urandom, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, w);
        @(negedge clk);
        vectors++;
        if (resp_rdata !== 32'h0000_0315 || resp_valid !== 1'b0) begin
            $display("FAIL word_load_hold: rdata=%h resp_valid=%b, required 00000315 0", resp_rdata, resp_valid);
            errs++;
        end
        do_req(1'b1, 1'b0, 8'h90, 32'h00AA_AADB, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, w);
        vectors++;
        if (mem[8'h90] !== 8'hDB || mem[8'h91] !== ref_mem[8'h91]) begin
            $display("FAIL byte_store_mem: 90=%h 91=%h, required DB %h", mem[8'h90], mem[8'h91], ref_mem[8'h91]);
            errs++;
        end
        do_req(1'b0, 1'b0, 8'h90, $urandom, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, w);
        vectors++;
        if (resp_rdata !== 32'h0000_00DB) begin
            $display("FAIL byte_load: rdata=%h, required 000000db", resp_rdata);
            errs++;
        end
    endtask

    task automatic test_wrap();
        int w;
        do_req(1'b1, 1'b1, 8'hFE, 32'h4433_2211, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, w);
        vectors++;
        if ({mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]} !== 32'h4433_2211) begin
            $display("FAIL wrap_mem: %h, required 44332211", {mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]});
            errs++;
        end
        do_req(1'b0, 1'b1, 8'hFF, $urandom, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, w);
    endtask

    task automatic test_back_to_back();
        int w;
        do_req(1'b1, 1'b1, 8'h20, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 8'h20, 32'h1234_5678, w);
        do_req(1'b0, 1'b1, 8'h20, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 8'h23, 32'h0000_0077, w);
        vectors++;
        if (w !== 0) begin
            $display("FAIL b2b_gap1: waited %0d idle cycles, required 0", w);
            errs++;
        end
        do_req(1'b1, 1'b0, 8'h23, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, w);
        vectors++;
        if (w !== 0) begin
            $display("FAIL b2b_gap2: waited %0d idle cycles, required 0", w);
            errs++;
        end
        do_req(1'b0, 1'b1, 8'h20, $urandom, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, w);
        vectors++;
        if (resp_rdata !== 32'h77FE_F00D) begin
            $display("FAIL b2b_load: rdata=%h, required 77fef00d", resp_rdata);
            errs++;
        end
    endtask

    task automatic test_reset_mid_xfer();
        int          w;
        int          seen;
        logic [31:0] d;
        d = $urandom;
        req_we = 1'b1; req_word = 1'b1; req_addr = 8'h40; req_wdata = d; req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (mem_address !== 8'h42 || mem_wren !== 1'b0) begin
            $display("FAIL rst_pre: addr=%h wren=%b, required 42 0", mem_address, mem_wren);
            errs++;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (mem_wren !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            $display("FAIL rst_async: wren=%b busy=%b resp_valid=%b, required 1 0 0", mem_wren, busy, resp_valid);
            errs++;
        end
        @(negedge clk);
        rst = 1'b0;
        ref_mem[8'h40] = d[7:0];
        ref_mem[8'h41] = d[15:8];
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            $display("FAIL rst_no_resp: %0d resp_valid cycles, required 0", seen);
            errs++;
        end
        vectors++;
        if ({mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} !==
            {ref_mem[8'h43], ref_mem[8'h42], ref_mem[8'h41], ref_mem[8'h40]}) begin
            $display("FAIL rst_partial: mem=%h, required %h", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]},
                     {ref_mem[8'h43], ref_mem[8'h42], ref_mem[8'h41], ref_mem[8'h40]});
            errs++;
        end
        do_req(1'b0, 1'b1, 8'h40, $urandom, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, w);
    endtask

    task automatic test_random();
        int w;
        for (int n = 0; n < 60; n++) begin
            do_req(1'($urandom), 1'($urandom), 8'($urandom_range(0, 15) | 8'hF0 & 8'($urandom)),
                   $urandom, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_and_byte();
        test_wrap();
        test_back_to_back();
        test_reset_mid_xfer();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
